// File: rtl/shift_inverter_seq.sv
// Sequential inverse of the 10-bit barrel shift/rotate stage: undoes the forward
// operation one bit per clock and flags lossy or impossible inputs.
module shift_inverter_seq #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_s,
    input  logic             in_d,
    input  logic             in_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_exact,
    output logic             out_bad
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work, work_step;
    logic [1:0]       cnt;
    logic             dir;   // 1 = right, 0 = left
    logic             mode;  // 1 = zero fill, 0 = rotate
    logic [1:0]       n;
    logic [WIDTH-1:0] vac_mask;

    // Shift-amount code is the bitwise complement of the amount.
    assign n = ~in_s;

    // Positions the forward shift vacated: top n bits for right, bottom n for left.
    always_comb begin
        vac_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_d) vac_mask[i] = (i >= WIDTH - int'(n));
            else      vac_mask[i] = (i < int'(n));
        end
    end

    always_comb begin
        work_step = work;
        if (dir) work_step = {(mode ? 1'b0 : work[0]), work[WIDTH-1:1]};
        else     work_step = {work[WIDTH-2:0], (mode ? 1'b0 : work[WIDTH-1])};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (n != 2'd0) ? SHIFT : DONE;
            SHIFT:   if (cnt == 2'd1) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            dir       <= 1'b0;
            mode      <= 1'b0;
            out_exact <= 1'b0;
            out_bad   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    work      <= in_data;
                    cnt       <= n;
                    dir       <= ~in_d;
                    mode      <= in_r;
                    out_exact <= ~(in_r & (n != 2'd0));
                    out_bad   <= in_r & (|(in_data & vac_mask));
                end
                SHIFT: begin
                    work <= work_step;
                    cnt  <= cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) & rst_n;
    assign out_valid = (state == DONE);
    assign out_data  = work;

endmodule
